// File: rtl/insn_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decoder-side
// instruction stream and the control-transfer redirect from execute.
interface insn_fetch_if;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] insn;
  logic [15:0] insn_ip;
  logic        insn_valid;
  logic        insn_ready;
  logic        redirect;
  logic [15:0] redirect_ip;

  modport master (
    output mem_addr, mem_rd, insn, insn_ip, insn_valid,
    input  mem_ack, mem_rdata, insn_ready, redirect, redirect_ip
  );

  modport slave (
    input  mem_addr, mem_rd, insn, insn_ip, insn_valid,
    output mem_ack, mem_rdata, insn_ready, redirect, redirect_ip
  );
endinterface

// File: rtl/insn_fetch.sv
// Instruction fetch unit: single-outstanding memory reader feeding a
// 2-entry {word, ip} buffer, with redirect flush and in-flight drop.
module insn_fetch #(
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  insn_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] fip, fip_nxt;
  logic [15:0] drop_addr, drop_addr_nxt;
  logic [15:0] ip_clean;

  logic [15:0] fifo_word [2];
  logic [15:0] fifo_ip   [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_nxt;
  logic        valid_q;

  logic        push, pop, flush;

  assign ip_clean = {bus.redirect_ip[15:1], 1'b0};

  // Redirect outranks both buffer updates; its returning word is discarded.
  assign flush     = bus.redirect;
  assign push      = (state == REQ) && bus.mem_ack && !bus.redirect;
  assign pop       = valid_q && bus.insn_ready && !bus.redirect;
  assign count_nxt = flush ? 2'd0 : (count + {1'b0, push} - {1'b0, pop});

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement leaves a value held, which would infer a latch.
    state_nxt     = state;
    fip_nxt       = fip;
    drop_addr_nxt = drop_addr;

    if (bus.redirect) begin
      fip_nxt = ip_clean;
    end else if (push) begin
      fip_nxt = fip + 16'd2;
    end

    case (state)
      IDLE: begin
        if (count_nxt < 2'd2) state_nxt = REQ;
      end
      REQ: begin
        if (bus.redirect && !bus.mem_ack) begin
          // The old read is still on the bus; remember it so it completes.
          drop_addr_nxt = fip;
          state_nxt     = DROP;
        end else if (bus.mem_ack) begin
          state_nxt = (count_nxt < 2'd2) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (bus.mem_ack) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst_n) begin
      state     <= IDLE;
      fip       <= RESET_IP;
      drop_addr <= RESET_IP;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      count     <= 2'd0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      fip       <= fip_nxt;
      drop_addr <= drop_addr_nxt;
      count     <= count_nxt;
      valid_q   <= (count_nxt != 2'd0);
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage is reset only because insn/insn_ip must read zero
    // out of reset; a deeper buffer would normally be left unreset.
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_word[i] <= 16'h0000;
        fifo_ip[i]   <= 16'h0000;
      end
    end else if (push) begin
      fifo_word[wr_ptr] <= bus.mem_rdata;
      fifo_ip[wr_ptr]   <= fip;
    end
  end

  assign bus.mem_rd     = (state != IDLE);
  assign bus.mem_addr   = (state == DROP) ? drop_addr : fip;
  assign bus.insn       = fifo_word[rd_ptr];
  assign bus.insn_ip    = fifo_ip[rd_ptr];
  assign bus.insn_valid = valid_q;

endmodule

// File: tb/tb_insn_fetch.sv
// Scoreboard bench for insn_fetch: expected instruction stream is the
// sequential address run from the last reset/redirect target.
module tb_insn_fetch;
  localparam logic [15:0] RESET_IP = 16'h0000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  insn_fetch_if bus ();

  insn_fetch #(.RESET_IP(RESET_IP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_popped = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Memory contents: word at byte address a is 8001 + a/2.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h8001 + {1'b0, a[15:1]};
  endfunction

  // Reference model: after reset or redirect the consumer must see ip, ip+2, ...
  logic [15:0] exp_q[$];
  logic [15:0] next_exp;

  function automatic void top_up();
    while (exp_q.size() < 4) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 16'd2;
    end
  endfunction

  function automatic void restart(input logic [15:0] ip);
    exp_q.delete();
    next_exp = ip & 16'hfffe;
    top_up();
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
    top_up();
  endtask

  // Memory responder: random or fixed wait states per request.
  int resp_max_wait = 0;
  bit resp_fixed    = 1'b1;
  bit stray_ack     = 1'b0;
  bit resp_busy     = 1'b0;
  int wait_left     = 0;

  always @(posedge clk) begin
    #1;
    if (stray_ack) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 16'hdead;
      resp_busy     = 1'b0;
    end else if (bus.mem_rd) begin
      if (!resp_busy) begin
        resp_busy = 1'b1;
        wait_left = resp_fixed ? resp_max_wait : int'($urandom_range(resp_max_wait, 0));
      end
      if (wait_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem_word(bus.mem_addr);
        resp_busy     = 1'b0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
        wait_left--;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 16'($urandom);
      resp_busy     = 1'b0;
    end
  end

  // Monitor: samples mid-cycle, pops the scoreboard on each accepted head.
  bit          prev_pending  = 1'b0;
  bit          prev_redirect = 1'b0;
  logic [15:0] prev_addr     = 16'h0000;

  always @(negedge clk) begin
    logic [15:0] e;
    if (rst_n === 1'b1) begin
      if (prev_pending) begin
        check("rd_held", bus.mem_rd, 1);
        check("addr_held", bus.mem_addr, prev_addr);
      end
      if (bus.mem_rd) check("addr_align", bus.mem_addr[0], 0);
      if (prev_redirect) check("valid_after_redirect", bus.insn_valid, 0);
      if (bus.insn_valid && bus.insn_ready && !bus.redirect) begin
        check("sb_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("insn_ip", bus.insn_ip, e);
          check("insn", bus.insn, mem_word(e));
          n_popped++;
        end
      end
    end
    prev_pending  = (rst_n === 1'b1) && bus.mem_rd && !bus.mem_ack;
    prev_redirect = (rst_n === 1'b1) && bus.redirect;
    prev_addr     = bus.mem_addr;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    restart(RESET_IP);
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int  n_rd;
    bit  found;
    bit  acked;
    int  pops_before;
    logic [15:0] ip;

    rst_n           = 1'b0;
    bus.insn_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_ip = 16'h0000;
    restart(RESET_IP);
    repeat (2) step();

    check("rst_valid", bus.insn_valid, 0);
    check("rst_rd", bus.mem_rd, 0);
    check("rst_insn", bus.insn, 16'h0000);
    check("rst_insn_ip", bus.insn_ip, 16'h0000);
    check("rst_addr", bus.mem_addr, RESET_IP);

    // Zero-wait memory, consumer always ready: one word per cycle.
    resp_fixed = 1'b1; resp_max_wait = 0;
    bus.insn_ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("first_rd", bus.mem_rd, 1);
    check("first_rd_addr", bus.mem_addr, RESET_IP);
    check("first_valid_low", bus.insn_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("b2b_valid", bus.insn_valid, 1);
      check("b2b_ip", bus.insn_ip, RESET_IP + 16'(2 * i));
    end

    // Stalled consumer: exactly two reads, then refill on the first pop.
    bus.insn_ready = 1'b0;
    do_reset();
    n_rd = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.mem_rd && bus.mem_ack) n_rd++;
    end
    check("reads_when_stalled", n_rd, 2);
    check("rd_low_when_full", bus.mem_rd, 0);
    bus.insn_ready = 1'b1;
    step();
    check("pop_head_ip", bus.insn_ip, 16'h0002);
    check("refill_rd", bus.mem_rd, 1);
    check("refill_addr", bus.mem_addr, 16'h0004);

    // Redirect while a 3-wait read of 0x0002 is pending.
    resp_max_wait = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      found = bus.mem_rd && (bus.mem_addr == 16'h0002);
    end
    check("reach_rd_0002", found, 1);
    bus.redirect = 1'b1; bus.redirect_ip = 16'h0041;
    restart(16'h0041);
    step();
    bus.redirect = 1'b0;
    acked = 1'b0;
    for (int i = 0; i < 10 && !acked; i++) begin
      check("drop_rd", bus.mem_rd, 1);
      check("drop_addr", bus.mem_addr, 16'h0002);
      acked = bus.mem_ack;
      if (!acked) step();
    end
    check("drop_acked", acked, 1);
    step();
    check("post_drop_rd", bus.mem_rd, 1);
    check("post_drop_addr", bus.mem_addr, 16'h0040);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      found = bus.insn_valid;
    end
    check("post_drop_valid", found, 1);
    check("post_drop_ip", bus.insn_ip, 16'h0040);

    // Redirect to the top of memory: fetch pointer wraps.
    resp_max_wait = 0;
    do_reset();
    repeat (3) step();
    bus.redirect = 1'b1; bus.redirect_ip = 16'hfffe;
    restart(16'hfffe);
    step();
    bus.redirect = 1'b0;
    check("wrap_valid_low", bus.insn_valid, 0);
    step();
    check("wrap_valid0", bus.insn_valid, 1);
    check("wrap_ip0", bus.insn_ip, 16'hfffe);
    step();
    check("wrap_valid1", bus.insn_valid, 1);
    check("wrap_ip1", bus.insn_ip, 16'h0000);

    // One-cycle reset with buffered data and a pending read; stray ack after.
    bus.insn_ready = 1'b0; resp_max_wait = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step();
      found = bus.insn_valid && bus.mem_rd && !bus.mem_ack;
    end
    check("busy_before_reset", found, 1);
    rst_n = 1'b0; stray_ack = 1'b1;
    restart(RESET_IP);
    step();
    rst_n = 1'b1; stray_ack = 1'b0;
    check("mid_rst_valid", bus.insn_valid, 0);
    check("mid_rst_rd", bus.mem_rd, 0);
    step();
    check("restart_rd", bus.mem_rd, 1);
    check("restart_addr", bus.mem_addr, RESET_IP);
    bus.insn_ready = 1'b1;
    pops_before = n_popped;
    repeat (20) step();
    check("restart_progress", n_popped > pops_before + 2, 1);

    // Randomized traffic: wait states, stalls, redirects, occasional resets.
    resp_fixed = 1'b0;
    pops_before = n_popped;
    for (int c = 0; c < 3000; c++) begin
      resp_max_wait = (c / 500) % 4;
      bus.insn_ready = ($urandom_range(99, 0) < 70);
      bus.redirect = 1'b0;
      rst_n = 1'b1;
      if ($urandom_range(99, 0) < 6) begin
        ip = 16'($urandom);
        bus.redirect = 1'b1;
        bus.redirect_ip = ip;
        restart(ip);
      end else if ($urandom_range(199, 0) == 0) begin
        rst_n = 1'b0;
        restart(RESET_IP);
      end
      step();
    end
    bus.redirect = 1'b0; rst_n = 1'b1;
    repeat (5) step();
    check("random_progress", n_popped > pops_before + 500, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 SHALL have parameter RESET_IP, default 16'h0000, meaning the byte address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 SHALL have port mem_addr  output  16  byte address of the instruction word being read; bit 0 always 0.
REQ-005 SHALL have port mem_rd  output  1  read request; held high with mem_addr stable until mem_ack.
REQ-006 SHALL have port mem_ack  input  1  read complete; mem_rdata valid in the same cycle; may rise in the first cycle of mem_rd.
REQ-007 SHALL have port mem_rdata  input  16  instruction word returned by memory.
REQ-008 SHALL have port insn  output  16  instruction word at the buffer head, fed to the decoder.
REQ-009 SHALL have port insn_ip  output  16  byte address of insn.
REQ-010 SHALL have port insn_valid  output  1  insn and insn_ip are valid.
REQ-011 SHALL have port insn_ready  input  1  consumer accepts the head when insn_valid is also high.
REQ-012 SHALL have port redirect  input  1  control transfer (the decoder's load_ip qualified by execute).
REQ-013 SHALL have port redirect_ip  input  16  new fetch address; bit 0 ignored and treated as 0.

Function
REQ-014 SHALL hold a 2-entry FIFO of {word, ip} pairs; insn/insn_ip SHALL show the head entry.
REQ-015 SHALL have a 16-bit fetch pointer fip; each accepted mem_ack SHALL advance it by 2, mod 2^16 (16'hfffe -> 16'h0000).
REQ-016 SHALL have states IDLE, REQ and DROP.
REQ-017 IDLE: mem_rd=0. Go to REQ when occupancy < 2.
REQ-018 REQ: mem_rd=1, mem_addr=fip. On mem_ack, write {mem_rdata, fip} to the FIFO tail. After mem_ack, stay in REQ if occupancy after that cycle < 2, else go to IDLE.
REQ-019 SHALL never have more than one outstanding request, and SHALL issue a request only when a FIFO slot is free, counting same-cycle pops. FIFO overflow SHALL be impossible.
REQ-020 A pop SHALL occur when insn_valid && insn_ready. A simultaneous push and pop with occupancy 2 SHALL not occur; with occupancy 1 it SHALL leave occupancy at 1.
REQ-021 Back-to-back throughput SHALL be one word per cycle when mem_ack is high in every cycle of mem_rd and insn_ready is held high.
REQ-022 Redirect in IDLE, or in REQ with mem_ack high: next cycle the FIFO SHALL be empty, fip=redirect_ip, and the state SHALL be REQ; that cycle's returning word SHALL be discarded.
REQ-023 Redirect in REQ with mem_ack low: the FIFO SHALL be flushed, fip SHALL be loaded with redirect_ip, and the state SHALL go to DROP. mem_addr SHALL remain the old address until ack.
REQ-024 DROP: mem_rd=1 with the old address. On mem_ack the data SHALL be discarded and the state SHALL go to REQ. A further redirect in DROP SHALL only reload fip.
REQ-025 Redirect SHALL take priority over a same-cycle pop and push; insn_valid SHALL be 0 in the cycle after any redirect.
REQ-026 insn_valid SHALL be registered and high iff occupancy > 0 and not in DROP after a flush.
REQ-027 insn, insn_ip and the state SHALL have no combinational path from insn_ready or mem_rdata. mem_rd may depend only on state.

Reset
REQ-028 While rst_n=0 at a clock edge: state SHALL become IDLE, the FIFO SHALL be emptied, fip SHALL be set to RESET_IP, and insn_valid, mem_rd SHALL be 0. insn and insn_ip SHALL be 16'h0000 and mem_addr SHALL be RESET_IP.
REQ-029 Reset asserted mid-request SHALL abandon the request; a mem_ack arriving after reset release while in IDLE SHALL be ignored.
REQ-030 The first mem_rd SHALL assert 1 cycle after rst_n rises (IDLE -> REQ).

Verification
REQ-031 Reset release, zero-wait memory returning 16'h8001, 16'h8002, 16'h8003 at 0x0000, 0x0002, 0x0004, insn_ready=1 -> insn_valid high from cycle 2, then one word per cycle with insn_ip 0x0000, 0x0002, 0x0004.
REQ-032 insn_ready=0 -> exactly 2 reads issued (0x0000, 0x0002), then mem_rd=0. Raising insn_ready -> head 0x0000 popped and a read of 0x0004 issued in the same cycle.
REQ-033 Redirect to 16'h0041 while a 3-wait-state read of 0x0002 is pending -> mem_addr stays 0x0002 until ack, the word is dropped, the next read is 0x0040, and the first valid insn_ip is 0x0040.
REQ-034 redirect_ip=16'hfffe, zero-wait memory -> insn_ip sequence 0xfffe, 0x0000.
REQ-035 rst_n low for one cycle with occupancy 2 and a pending read -> next cycle insn_valid=0, mem_rd=0, and fetch restarts at RESET_IP.
